// File: rtl/rob_commit_unit_pkg.sv
// rob_commit_unit_pkg: shared sizes and entry type for the reorder buffer commit slice
package rob_commit_unit_pkg;
  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;
  localparam int REG_SEL = 5;
  localparam int DATA_LEN = 32;
  localparam int COMMIT_WIDTH = 2;
  typedef logic [RRF_SEL-1:0] rrf_tag_t;
  typedef logic [REG_SEL-1:0] reg_num_t;
  typedef struct packed {
    logic     valid;
    logic     finished;
    logic     dst_en;
    reg_num_t dst_num;
  } rob_entry_t;
endpackage

// File: rtl/rob_entry_array.sv
// rob_entry_array: per-tag ROB storage with dispatch, finish, head-pair retire clear and two head read ports
module rob_entry_array
  import rob_commit_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               dp1_we,
  input  rrf_tag_t           dp1_tag,
  input  reg_num_t           dp1_dst_num,
  input  logic               dp1_dst_en,
  input  logic               dp2_we,
  input  rrf_tag_t           dp2_tag,
  input  reg_num_t           dp2_dst_num,
  input  logic               dp2_dst_en,
  input  logic               fin1_we,
  input  rrf_tag_t           fin1_tag,
  input  logic               fin2_we,
  input  rrf_tag_t           fin2_tag,
  input  logic               clr1_we,
  input  logic               clr2_we,
  input  rrf_tag_t           rd1_ptr,
  input  rrf_tag_t           rd2_ptr,
  output rob_entry_t         rd1,
  output rob_entry_t         rd2,
  output logic [RRF_NUM-1:0] valid
);
  logic [RRF_NUM-1:0] fin, dst_en;
  reg_num_t dst_num [RRF_NUM];
  assign rd1 = {valid[rd1_ptr], fin[rd1_ptr], dst_en[rd1_ptr], dst_num[rd1_ptr]};
  assign rd2 = {valid[rd2_ptr], fin[rd2_ptr], dst_en[rd2_ptr], dst_num[rd2_ptr]};
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      valid  <= '0;
      fin    <= '0;
      dst_en <= '0;
    end else begin
      for (int i = 0; i < RRF_NUM; i++) begin
        if ((fin1_we && fin1_tag == rrf_tag_t'(i) && valid[i]) || (fin2_we && fin2_tag == rrf_tag_t'(i) && valid[i]))
          fin[i] <= 1'b1;
        if ((clr1_we && rd1_ptr == rrf_tag_t'(i)) || (clr2_we && rd2_ptr == rrf_tag_t'(i))) begin
          valid[i] <= 1'b0;
          fin[i]   <= 1'b0;
        end
        if ((dp1_we && dp1_tag == rrf_tag_t'(i)) || (dp2_we && dp2_tag == rrf_tag_t'(i))) begin
          valid[i]  <= 1'b1;
          fin[i]    <= 1'b0;
          dst_en[i] <= (dp1_we && dp1_tag == rrf_tag_t'(i)) ? dp1_dst_en : dp2_dst_en;
        end
      end
    end
  always_ff @(posedge clk_i)
    for (int i = 0; i < RRF_NUM; i++)
      if ((dp1_we && dp1_tag == rrf_tag_t'(i)) || (dp2_we && dp2_tag == rrf_tag_t'(i)))
        dst_num[i] <= (dp1_we && dp1_tag == rrf_tag_t'(i)) ? dp1_dst_num : dp2_dst_num;
endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order two-wide retirement from a tag-indexed reorder buffer
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               dp1_we_i,
  input  logic [RRF_SEL-1:0] dp1_rrftag_i,
  input  logic [REG_SEL-1:0] dp1_dst_num_i,
  input  logic               dp1_dst_en_i,
  input  logic               dp2_we_i,
  input  logic [REG_SEL-1:0] dp2_dst_num_i,
  input  logic               dp2_dst_en_i,
  input  logic               fin1_we_i,
  input  logic [RRF_SEL-1:0] fin1_rrftag_i,
  input  logic               fin2_we_i,
  input  logic [RRF_SEL-1:0] fin2_rrftag_i,
  input  logic               commit_stall_i,
  output logic [1:0]         com_inst_num_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic               completed1_we_o,
  output logic [REG_SEL-1:0] completed1_dst_num_o,
  output logic [RRF_SEL-1:0] completed1_rrftag_o,
  output logic               completed2_we_o,
  output logic [REG_SEL-1:0] completed2_dst_num_o,
  output logic [RRF_SEL-1:0] completed2_rrftag_o,
  output logic [RRF_SEL:0]   occupancy_o,
  output logic               overflow_err_o
);
  rrf_tag_t comptr, comptr1, dp2_tag;
  rob_entry_t h0, h1;
  logic [RRF_NUM-1:0] valid;
  logic [RRF_SEL:0] occupancy;
  logic [RRF_SEL+1:0] occ_sum;
  logic [1:0] ndisp, ncom;
  logic c0, c1, full, accept, overflow_err;
  assign comptr1 = comptr + rrf_tag_t'(1);
  assign dp2_tag = dp1_rrftag_i + rrf_tag_t'(1);
  assign c0 = !commit_stall_i && h0.valid && h0.finished;
  assign c1 = c0 && h1.valid && h1.finished;
  assign ncom = {c1, c0 & ~c1};
  assign ndisp = dp1_we_i ? (dp2_we_i ? 2'd2 : 2'd1) : 2'd0;
  assign occ_sum = {1'b0, occupancy} + {{RRF_SEL{1'b0}}, ndisp};
  // an entry retiring this cycle is still valid, so dispatch into it is overflow
  assign full = occ_sum > (RRF_SEL+2)'(RRF_NUM) || valid[dp1_rrftag_i] || (dp2_we_i && valid[dp2_tag]);
  assign accept = dp1_we_i && !full;
  rob_entry_array u_arr (
    .clk_i, .reset_i,
    .dp1_we(accept), .dp1_tag(dp1_rrftag_i), .dp1_dst_num(dp1_dst_num_i), .dp1_dst_en(dp1_dst_en_i),
    .dp2_we(accept && dp2_we_i), .dp2_tag, .dp2_dst_num(dp2_dst_num_i), .dp2_dst_en(dp2_dst_en_i),
    .fin1_we(fin1_we_i), .fin1_tag(fin1_rrftag_i), .fin2_we(fin2_we_i), .fin2_tag(fin2_rrftag_i),
    .clr1_we(c0), .clr2_we(c1), .rd1_ptr(comptr), .rd2_ptr(comptr1),
    .rd1(h0), .rd2(h1), .valid
  );
  assign com_inst_num_o = ncom;
  assign comptr_o = comptr;
  assign occupancy_o = occupancy;
  assign overflow_err_o = overflow_err;
  assign completed1_we_o = c0 && h0.dst_en;
  assign completed1_dst_num_o = c0 ? h0.dst_num : '0;
  assign completed1_rrftag_o = c0 ? comptr : '0;
  assign completed2_we_o = c1 && h1.dst_en;
  assign completed2_dst_num_o = c1 ? h1.dst_num : '0;
  assign completed2_rrftag_o = c1 ? comptr1 : '0;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      comptr       <= '0;
      occupancy    <= '0;
      overflow_err <= 1'b0;
    end else begin
      comptr       <= comptr + rrf_tag_t'(ncom);
      occupancy    <= occupancy + (RRF_SEL+1)'(accept ? ndisp : 2'd0) - (RRF_SEL+1)'(ncom);
      if (dp1_we_i && full) overflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed table plus hand sequences for the ROB commit unit
module tb_rob_commit_unit;
  logic clk_i = 1'b0, reset_i = 1'b0;
  logic dp1_we_i, dp1_dst_en_i, dp2_we_i, dp2_dst_en_i, fin1_we_i, fin2_we_i, commit_stall_i;
  logic [5:0] dp1_rrftag_i, fin1_rrftag_i, fin2_rrftag_i;
  logic [4:0] dp1_dst_num_i, dp2_dst_num_i;
  logic [1:0] com_inst_num_o;
  logic [5:0] comptr_o, completed1_rrftag_o, completed2_rrftag_o;
  logic completed1_we_o, completed2_we_o, overflow_err_o;
  logic [4:0] completed1_dst_num_o, completed2_dst_num_o;
  logic [6:0] occupancy_o;
  int checks = 0, passed = 0;

  typedef struct {
    int dp1, tag, d1, e1, dp2, d2, e2, f1, ft1, f2, ft2, st;
    int com, w1, n1, t1, w2, n2, t2, ptr, occ, err;
  } vec_t;
  vec_t v [12];

  rob_commit_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dp1_we_i(dp1_we_i), .dp1_rrftag_i(dp1_rrftag_i), .dp1_dst_num_i(dp1_dst_num_i), .dp1_dst_en_i(dp1_dst_en_i),
    .dp2_we_i(dp2_we_i), .dp2_dst_num_i(dp2_dst_num_i), .dp2_dst_en_i(dp2_dst_en_i),
    .fin1_we_i(fin1_we_i), .fin1_rrftag_i(fin1_rrftag_i), .fin2_we_i(fin2_we_i), .fin2_rrftag_i(fin2_rrftag_i),
    .commit_stall_i(commit_stall_i), .com_inst_num_o(com_inst_num_o), .comptr_o(comptr_o),
    .completed1_we_o(completed1_we_o), .completed1_dst_num_o(completed1_dst_num_o), .completed1_rrftag_o(completed1_rrftag_o),
    .completed2_we_o(completed2_we_o), .completed2_dst_num_o(completed2_dst_num_o), .completed2_rrftag_o(completed2_rrftag_o),
    .occupancy_o(occupancy_o), .overflow_err_o(overflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic idle();
    dp1_we_i = 0; dp1_rrftag_i = 0; dp1_dst_num_i = 0; dp1_dst_en_i = 0;
    dp2_we_i = 0; dp2_dst_num_i = 0; dp2_dst_en_i = 0;
    fin1_we_i = 0; fin1_rrftag_i = 0; fin2_we_i = 0; fin2_rrftag_i = 0; commit_stall_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input int t, input int d1, input int d2, input bit two);
    idle();
    dp1_we_i = 1; dp1_rrftag_i = 6'(t); dp1_dst_num_i = 5'(d1); dp1_dst_en_i = 1;
    dp2_we_i = two; dp2_dst_num_i = 5'(d2); dp2_dst_en_i = 1;
    tick();
    idle();
  endtask

  task automatic fin(input int a, input int b);
    idle();
    fin1_we_i = 1; fin1_rrftag_i = 6'(a); fin2_we_i = 1; fin2_rrftag_i = 6'(b);
    tick();
    idle();
  endtask

  task automatic chk_outs(input string p, input vec_t e);
    chk({p, " com"}, int'(com_inst_num_o), e.com);
    chk({p, " we1"}, int'(completed1_we_o), e.w1);
    chk({p, " dst1"}, int'(completed1_dst_num_o), e.n1);
    chk({p, " tag1"}, int'(completed1_rrftag_o), e.t1);
    chk({p, " we2"}, int'(completed2_we_o), e.w2);
    chk({p, " dst2"}, int'(completed2_dst_num_o), e.n2);
    chk({p, " tag2"}, int'(completed2_rrftag_o), e.t2);
    chk({p, " comptr"}, int'(comptr_o), e.ptr);
    chk({p, " occ"}, int'(occupancy_o), e.occ);
    chk({p, " err"}, int'(overflow_err_o), e.err);
  endtask

  initial begin
    vec_t z;
    //       dp1 tag d1 e1 dp2 d2 e2 f1 ft1 f2 ft2 st | com w1 n1 t1 w2 n2 t2 ptr occ err
    v[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{1, 0, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    v[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    v[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 3, 0, 1, 4, 1, 0, 2, 0};
    v[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    v[6]  = '{1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    v[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 0,   0, 0, 0, 0, 0, 0, 0, 2, 1, 0};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 2, 1, 0};
    v[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 7, 2, 0, 0, 0, 2, 1, 0};
    v[10] = '{0, 3, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
    v[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
    z = v[0];
    idle();
    #2;
    chk_outs("in_reset", z);
    tick();
    tick();
    reset_i = 1;
    for (int i = 0; i < 12; i++) begin
      dp1_we_i = v[i].dp1 != 0; dp1_rrftag_i = 6'(v[i].tag); dp1_dst_num_i = 5'(v[i].d1); dp1_dst_en_i = v[i].e1 != 0;
      dp2_we_i = v[i].dp2 != 0; dp2_dst_num_i = 5'(v[i].d2); dp2_dst_en_i = v[i].e2 != 0;
      fin1_we_i = v[i].f1 != 0; fin1_rrftag_i = 6'(v[i].ft1); fin2_we_i = v[i].f2 != 0; fin2_rrftag_i = 6'(v[i].ft2);
      commit_stall_i = v[i].st != 0;
      #4;
      chk_outs($sformatf("row%0d", i), v[i]);
      tick();
    end
    idle();
    for (int t = 3; t < 63; t += 2) begin
      disp(t, 1, 2, 1);
      fin(t, t + 1);
      tick();
    end
    chk("walk comptr", int'(comptr_o), 63);
    chk("walk occ", int'(occupancy_o), 0);
    disp(63, 10, 11, 1);
    fin(63, 0);
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 10, 63, 1, 11, 0, 63, 2, 0};
    chk_outs("wrap", z);
    tick();
    chk("wrap comptr", int'(comptr_o), 1);
    chk("wrap occ", int'(occupancy_o), 0);
    for (int t = 1; t < 64; t += 2) disp(t, 6, 7, 1);
    chk("full occ", int'(occupancy_o), 64);
    chk("full err", int'(overflow_err_o), 0);
    chk("full com", int'(com_inst_num_o), 0);
    disp(1, 9, 0, 0);
    chk("ovf occ", int'(occupancy_o), 64);
    chk("ovf err", int'(overflow_err_o), 1);
    tick();
    tick();
    chk("ovf sticky", int'(overflow_err_o), 1);
    chk("ovf occ hold", int'(occupancy_o), 64);
    reset_i = 0;
    tick();
    reset_i = 1;
    chk("post reset err", int'(overflow_err_o), 0);
    chk("post reset occ", int'(occupancy_o), 0);
    disp(0, 1, 2, 1);
    disp(2, 3, 4, 1);
    disp(4, 5, 0, 0);
    chk("five occ", int'(occupancy_o), 5);
    fin(0, 1);
    #3;
    chk("pre reset com", int'(com_inst_num_o), 2);
    reset_i = 0;
    #1;
    z = v[0];
    chk_outs("async reset", z);
    tick();
    chk_outs("held reset", z);
    reset_i = 1;
    tick();
    chk("released occ", int'(occupancy_o), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer that retires instructions in order. It produces the commit-side signals the rename stage consumes: retire count, ARF completed-write number/enable, and the completed RRF tag.
- Entries are indexed by RRF tag, so entry i is the instruction that owns RRF entry i.
- Dispatch writes the entry at the rename pointer. Execution units mark entries finished. The block retires up to two finished entries per cycle from the commit pointer.

Parameters:
- RRF_NUM, 64, number of ROB/RRF entries; must be a power of 2.
- RRF_SEL, 6, log2(RRF_NUM).
- REG_SEL, 5, architectural register index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset; asynchronous assert, active-low.
- dp1_we_i  in  1  dispatch slot 1 valid.
- dp1_rrftag_i  in  RRF_SEL  entry for slot 1 (the rename pointer).
- dp1_dst_num_i  in  REG_SEL  destination architectural register, slot 1.
- dp1_dst_en_i  in  1  slot 1 writes a register.
- dp2_we_i  in  1  dispatch slot 2 valid; its entry is dp1_rrftag_i+1 mod RRF_NUM.
- dp2_dst_num_i  in  REG_SEL  destination architectural register, slot 2.
- dp2_dst_en_i  in  1  slot 2 writes a register.
- fin1_we_i  in  1  finish port 1 valid.
- fin1_rrftag_i  in  RRF_SEL  tag finished on port 1.
- fin2_we_i  in  1  finish port 2 valid.
- fin2_rrftag_i  in  RRF_SEL  tag finished on port 2.
- commit_stall_i  in  1  block all retirement this cycle.
- com_inst_num_o  out  2  instructions retired this cycle (0..2).
- comptr_o  out  RRF_SEL  commit pointer (oldest entry).
- completed1_we_o  out  1  ARF write for the first retiree.
- completed1_dst_num_o  out  REG_SEL  ARF register for the first retiree.
- completed1_rrftag_o  out  RRF_SEL  RRF tag of the first retiree.
- completed2_we_o  out  1  ARF write for the second retiree.
- completed2_dst_num_o  out  REG_SEL  ARF register for the second retiree.
- completed2_rrftag_o  out  RRF_SEL  RRF tag of the second retiree.
- occupancy_o  out  RRF_SEL+1  number of live entries.
- overflow_err_o  out  1  sticky error flag.

Behaviour:
- State per entry: valid, finished, dst_en, dst_num. Also comptr and occupancy.
- Reset (reset_i=0), asynchronous:
  - all valid and finished bits clear;
  - comptr=0, occupancy=0, overflow_err_o=0;
  - all commit outputs read 0.
- Dispatch takes effect on the edge:
  - sets valid=1 and finished=0, and latches dst_en and dst_num for the slot's entry;
  - dp2_we_i without dp1_we_i is illegal and is ignored.
- Finish takes effect on the edge:
  - sets finished=1 only if the entry is valid;
  - finish to an invalid entry is ignored;
  - both ports naming the same tag is legal.
- Commit is combinational from registered state:
  - c0 = !commit_stall_i & valid[comptr] & finished[comptr].
  - c1 = c0 & valid[comptr+1] & finished[comptr+1], indices mod RRF_NUM.
  - com_inst_num_o = c0+c1.
  - completedN_we_o = cN & dst_en; completedN_rrftag_o = entry index; completedN_dst_num_o = entry dst_num.
  - When cN=0, the port outputs are all 0.
- Edge after a commit:
  - retired entries have valid and finished cleared;
  - comptr += com_inst_num_o, with wrap;
  - occupancy += dispatched − com_inst_num_o.
- Latency:
  - an entry finished at edge k can retire in cycle k, i.e. visible on outputs after that edge;
  - a finish and a commit of the same entry never coincide, because the finished bit is registered.
- Wrap-around:
  - comptr at RRF_NUM−1 with two ready entries retires RRF_NUM−1 and 0, then comptr=1.
  - Dispatch slot 2 also wraps.
- Full: dispatch when occupancy + number dispatched > RRF_NUM, or to an entry already valid:
  - the write is dropped;
  - overflow_err_o is set and stays set until reset.
- Simultaneous dispatch into an entry retiring the same cycle counts as overflow, since the entry is still valid.
- In-order rule: c1 requires c0; a finished entry behind an unfinished head never retires.
- Reset mid-operation clears everything immediately; no partial commit is visible.

Decomposition:
- Shared consts header: RRF_NUM, RRF_SEL, REG_SEL, DATA_LEN, and a COMMIT_WIDTH=2 constant.
- One sub-module, rob_entry_array: storage with dispatch and finish writes, two read ports at comptr and comptr+1, and per-entry clear on retire.
- Pointer, occupancy and commit logic stay in the top module.

Test Plan:
- Reset low mid-run with 5 live entries → all outputs 0, occupancy_o=0, comptr_o=0 while reset_i=0.
- Dispatch tags 0,1 (dst x3,x4, dst_en=1), finish 1 then 0 → no retire while only tag 1 is finished; the cycle after tag 0 finishes: com_inst_num_o=2, completed1 = x3/tag 0, completed2 = x4/tag 1; comptr_o becomes 2.
- comptr=63 with entries 63 and 0 finished → com_inst_num_o=2, rrftags 63 and 0, comptr_o=1 next cycle.
- Head finished, dst_en=0, commit_stall_i=1 → com_inst_num_o=0; release stall → com_inst_num_o=1, completed1_we_o=0, completed1_rrftag_o=head.
- Fill to 64, then dispatch again → overflow_err_o=1 and stays 1; occupancy_o=64 unchanged.
- Finish on both ports to the same tag, plus a finish to an invalid tag → only the valid entry is marked finished; no spurious retire.
